// File: rtl/mmio_io_hub_pkg.sv
// ============================================================================
// Module : mmio_io_hub_pkg
// Brief  : Shared I/O window map: register indices, CTRL/STATUS bit positions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mmio_io_hub_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

    // Word index within the 64-byte window (byte offset = index * 4)
    typedef enum logic [3:0] {
        REG_SEG    = 4'd0,
        REG_LED    = 4'd1,
        REG_SW     = 4'd2,
        REG_TIMER  = 4'd3,
        REG_CMP    = 4'd4,
        REG_CTRL   = 4'd5,
        REG_STATUS = 4'd6
    } io_reg_e;

    localparam int CTRL_TMR_EN    = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int ST_TMR_MATCH   = 0;
    localparam int ST_SW_CHG      = 1;

    function automatic logic [31:0] io_addr(input logic [31:0] base, input io_reg_e idx);
        return {base[31:6], idx, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// ============================================================================
// Module : io_debounce
// Brief  : 2-flop synchroniser plus whole-vector debouncer with change pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_debounce #(
    parameter int          W   = 16,
    parameter logic [19:0] CYC = 20'd100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         chg_pulse
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [19:0]  cnt;
    logic         differs;
    logic         expire;

    assign differs   = (sync2 != dout);
    assign expire    = differs && (cnt == CYC - 20'd1);
    // Pulses in the cycle before dout takes the new value, so the flag and value land together
    assign chg_pulse = expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (!differs) begin
                cnt <= '0;
            end else if (expire) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_io_hub.sv
// ============================================================================
// Module : mmio_io_hub
// Brief  : Memory-mapped I/O hub: address decode, seg7/LED regs, switches, timer, irq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_io_hub
    import mmio_io_hub_pkg::*;
#(
    parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
    parameter int          SW_W         = 16,
    parameter int          LED_W        = 16,
    parameter logic [19:0] DEBOUNCE_CYC = 20'd100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic [SW_W-1:0]  sw,
    output logic             dmem_we,
    output logic [31:0]      rdata,
    output logic [31:0]      seg_value,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    logic            io_hit;
    logic [3:0]      reg_idx;
    logic            io_wr;
    logic [SW_W-1:0] sw_db;
    logic            sw_chg;
    logic [31:0]     timer;
    logic [31:0]     cmp;
    logic [1:0]      ctrl;
    logic [1:0]      status;

    logic [31:0]     timer_nxt;
    logic [1:0]      ctrl_nxt;
    logic [1:0]      status_nxt;
    logic [1:0]      status_clr;
    logic            match_set;
    logic            irq_nxt;
    logic [31:0]     io_rdata;

    // Byte-lane bits and the load strobe carry no information for this block
    logic            unused_ok;
    assign unused_ok = ^{addr[1:0], mem_read};

    assign io_hit  = (addr[31:6] == IO_BASE[31:6]);
    assign reg_idx = addr[5:2];
    assign io_wr   = mem_write && io_hit;
    assign dmem_we = mem_write && !io_hit;

    io_debounce #(
        .W   (SW_W),
        .CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .din       (sw),
        .dout      (sw_db),
        .chg_pulse (sw_chg)
    );

    always_comb begin
        timer_nxt  = timer;
        ctrl_nxt   = ctrl;
        status_clr = 2'b00;
        match_set  = ctrl[CTRL_TMR_EN] && (timer == cmp);

        if (io_wr && reg_idx == REG_TIMER) begin
            timer_nxt = wdata;
        end else if (ctrl[CTRL_TMR_EN]) begin
            timer_nxt = timer + 32'd1;
        end
        if (io_wr && reg_idx == REG_CTRL) begin
            ctrl_nxt = wdata[1:0];
        end
        if (io_wr && reg_idx == REG_STATUS) begin
            status_clr = wdata[1:0];
        end

        // Set events are OR-ed after the clear so a coincident set survives
        status_nxt               = status & ~status_clr;
        status_nxt[ST_TMR_MATCH] = status_nxt[ST_TMR_MATCH] | match_set;
        status_nxt[ST_SW_CHG]    = status_nxt[ST_SW_CHG] | sw_chg;
        irq_nxt                  = ctrl_nxt[CTRL_IRQ_EN] && (status_nxt != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_value <= '0;
            led       <= '0;
            timer     <= '0;
            cmp       <= '0;
            ctrl      <= '0;
            status    <= '0;
            irq       <= 1'b0;
        end else begin
            if (io_wr && reg_idx == REG_SEG) seg_value <= wdata;
            if (io_wr && reg_idx == REG_LED) led       <= wdata[LED_W-1:0];
            if (io_wr && reg_idx == REG_CMP) cmp       <= wdata;
            timer  <= timer_nxt;
            ctrl   <= ctrl_nxt;
            status <= status_nxt;
            irq    <= irq_nxt;
        end
    end

    always_comb begin
        io_rdata = '0;
        case (reg_idx)
            REG_SEG:    io_rdata = seg_value;
            REG_LED:    io_rdata[LED_W-1:0] = led;
            REG_SW:     io_rdata[SW_W-1:0]  = sw_db;
            REG_TIMER:  io_rdata = timer;
            REG_CMP:    io_rdata = cmp;
            REG_CTRL:   io_rdata[1:0] = ctrl;
            REG_STATUS: io_rdata[1:0] = status;
            default:    io_rdata = '0;
        endcase
    end

    assign rdata = io_hit ? io_rdata : dmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_hub.sv
// ============================================================================
// Module : tb_mmio_io_hub
// Brief  : Directed scoreboard bench for mmio_io_hub with a short debounce window.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_io_hub;
    import mmio_io_hub_pkg::*;

    localparam logic [31:0] BASE = IO_BASE_DEFAULT;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] wdata;
    logic [31:0] dmem_rdata;
    logic [15:0] sw;
    logic        dmem_we;
    logic [31:0] rdata;
    logic [31:0] seg_value;
    logic [15:0] led;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    mmio_io_hub #(
        .IO_BASE      (BASE),
        .SW_W         (16),
        .LED_W        (16),
        .DEBOUNCE_CYC (20'd4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .wdata      (wdata),
        .dmem_rdata (dmem_rdata),
        .sw         (sw),
        .dmem_we    (dmem_we),
        .rdata      (rdata),
        .seg_value  (seg_value),
        .led        (led),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(tag, e);
        compare(obs);
    endtask

    task automatic rd_check(input string tag, input io_reg_e idx, input logic [31:0] e);
        expect_val(tag, e);
        addr     = io_addr(BASE, idx);
        mem_read = 1'b1;
        #1;
        compare(rdata);
        mem_read = 1'b0;
    endtask

    task automatic wr(input io_reg_e idx, input logic [31:0] d);
        addr      = io_addr(BASE, idx);
        wdata     = d;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = '0; mem_read = 1'b0; mem_write = 1'b0;
        wdata = '0; dmem_rdata = '0; sw = '0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check_out("rst_seg", seg_value, 32'h0);
        check_out("rst_led", {16'h0, led}, 32'h0);
        check_out("rst_irq", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            rd_check($sformatf("rst_rd%0d", i), io_reg_e'(i), 32'h0);
        end

        // Debounced switch change with irq enabled
        wr(REG_CTRL, 32'h2);
        sw = 16'h8001;
        repeat (5) tick();
        rd_check("sw_early", REG_SW, 32'h0);
        tick();
        rd_check("sw_new", REG_SW, 32'h0000_8001);
        rd_check("sw_status", REG_STATUS, 32'h2);
        check_out("sw_irq", {31'h0, irq}, 32'h1);

        // Return to zero, clear flag, then bounce shorter than the window
        sw = 16'h0000;
        repeat (6) tick();
        rd_check("sw_back", REG_SW, 32'h0);
        wr(REG_STATUS, 32'h2);
        rd_check("w1c_sw", REG_STATUS, 32'h0);
        check_out("w1c_sw_irq", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            tick(); tick();
        end
        sw = 16'h0000;
        repeat (4) tick();
        rd_check("bounce_sw", REG_SW, 32'h0);
        rd_check("bounce_status", REG_STATUS, 32'h0);

        // Timer compare match, W1C, wrap
        wr(REG_CMP, 32'd10);
        wr(REG_TIMER, 32'd5);
        wr(REG_CTRL, 32'h3);
        repeat (5) tick();
        rd_check("tmr_at_cmp", REG_TIMER, 32'd10);
        rd_check("match_not_yet", REG_STATUS, 32'h0);
        tick();
        rd_check("match_set", REG_STATUS, 32'h1);
        check_out("match_irq", {31'h0, irq}, 32'h1);
        wr(REG_STATUS, 32'h1);
        rd_check("match_clr", REG_STATUS, 32'h0);
        check_out("match_clr_irq", {31'h0, irq}, 32'h0);
        wr(REG_TIMER, 32'hFFFF_FFFF);
        rd_check("tmr_load", REG_TIMER, 32'hFFFF_FFFF);
        tick();
        rd_check("tmr_wrap", REG_TIMER, 32'h0);

        // SEG/LED stores stay off data memory; other addresses go to it
        addr = io_addr(BASE, REG_SEG); wdata = 32'hDEAD_BEEF; mem_write = 1'b1;
        #1;
        check_out("seg_dmem_we", {31'h0, dmem_we}, 32'h0);
        tick();
        mem_write = 1'b0;
        check_out("seg_value", seg_value, 32'hDEAD_BEEF);
        wr(REG_LED, 32'h0000_1234);
        check_out("led_value", {16'h0, led}, 32'h0000_1234);
        rd_check("led_rd", REG_LED, 32'h0000_1234);
        addr = 32'h1001_0000; wdata = 32'h5555_AAAA; mem_write = 1'b1;
        #1;
        check_out("dmem_we", {31'h0, dmem_we}, 32'h1);
        mem_write = 1'b0; mem_read = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1;
        check_out("dmem_rdata", rdata, 32'hCAFE_F00D);
        mem_read = 1'b0;
        rd_check("unmapped", io_reg_e'(4'd9), 32'h0);

        // W1C coinciding with a match set: set wins
        wr(REG_CTRL, 32'h0);
        wr(REG_TIMER, 32'd20);
        wr(REG_CMP, 32'd20);
        wr(REG_STATUS, 32'h3);
        wr(REG_CTRL, 32'h1);
        wr(REG_STATUS, 32'h1);
        rd_check("w1c_vs_set", REG_STATUS, 32'h1);
        rd_check("tmr_run", REG_TIMER, 32'd21);

        // Reset in the middle of a debounce
        wr(REG_CTRL, 32'h0);
        wr(REG_STATUS, 32'h3);
        sw = 16'h00F0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sw = 16'h0000;
        repeat (6) tick();
        rd_check("mid_rst_sw", REG_SW, 32'h0);
        rd_check("mid_rst_status", REG_STATUS, 32'h0);
        check_out("mid_rst_seg", seg_value, 32'h0);
        rd_check("mid_rst_timer", REG_TIMER, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
